// File: rtl/lcd_rx_capture.sv
// Parallel RGB LCD receiver: re-times the pixel bus, regenerates x/y coordinates
// and frame/line markers, measures active geometry and tracks lock on stable video.
module lcd_rx_capture #(
  parameter logic        VS_POL  = 1'b1,
  parameter logic [19:0] TIMEOUT = 20'd1048575
) (
  input  logic        clk_in,
  input  logic        sys_rst,
  input  logic [23:0] rgb_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        sof,
  output logic        eol,
  output logic [9:0]  h_active,
  output logic [9:0]  v_active,
  output logic        frame_locked,
  output logic        geom_err,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {UNLOCKED, CAND, LOCKED} state_t;
  state_t state, state_nxt;

  logic [23:0] s1_rgb, s2_rgb;
  logic        s1_hs, s2_hs_unused;
  logic        s1_vs, s2_vs, s1_de, s2_de;
  logic        s1_deq, s2_deq, vs_rise, line_end;

  logic [10:0] x_cnt, line_w, cur_w, cur_w_nxt;
  logic [9:0]  y_cnt, y_nxt;
  logic        seen_vs, ovf, ovf_nxt, mism, mism_nxt, frame_good;
  logic [19:0] wd_cnt;
  logic        wd_hit;

  logic        eval, tick, snap_good;
  logic [9:0]  snap_w, snap_h, cand_w, cand_h;
  logic        same, load_cand, load_act, err;

  assign s1_deq   = s1_de & ~s1_vs;
  assign s2_deq   = s2_de & ~s2_vs;
  assign vs_rise  = s1_vs & ~s2_vs;
  assign line_end = s2_deq & ~s1_deq;
  assign wd_hit   = (wd_cnt == TIMEOUT);

  // Frame metrics as they stand including a line that ends this very cycle,
  // so a vsync edge coinciding with the last eol still sees that line.
  always_comb begin
    line_w    = x_cnt + 11'd1;
    ovf_nxt   = ovf;
    mism_nxt  = mism;
    cur_w_nxt = cur_w;
    y_nxt     = y_cnt;
    if (s2_deq && x_cnt[10]) ovf_nxt = 1'b1;
    if (line_end) begin
      if (y_cnt == '1) ovf_nxt = 1'b1;
      else             y_nxt   = y_cnt + 10'd1;
      if (y_cnt == '0)          cur_w_nxt = line_w;
      else if (line_w != cur_w) mism_nxt  = 1'b1;
    end
    frame_good = (y_nxt != '0) && !mism_nxt && !ovf_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      s1_rgb <= '0; s2_rgb <= '0;
      s1_hs  <= 1'b0; s2_hs_unused <= 1'b0;
      s1_vs  <= 1'b0; s2_vs <= 1'b0;
      s1_de  <= 1'b0; s2_de <= 1'b0;
      pix_data <= '0; pix_valid <= 1'b0;
      pix_x <= '0; pix_y <= '0;
      sof <= 1'b0; eol <= 1'b0;
      x_cnt <= '0; y_cnt <= '0; cur_w <= '0;
      ovf <= 1'b0; mism <= 1'b0; seen_vs <= 1'b0;
      wd_cnt <= '0;
      eval <= 1'b0; tick <= 1'b0; snap_good <= 1'b0;
      snap_w <= '0; snap_h <= '0;
    end else begin
      s1_rgb <= rgb_in;
      s1_hs  <= hsync_in;
      s1_vs  <= (vsync_in == VS_POL);
      s1_de  <= de_in;
      s2_rgb <= s1_rgb;
      s2_hs_unused <= s1_hs;
      s2_vs  <= s1_vs;
      s2_de  <= s1_de;

      pix_data  <= s2_rgb;
      pix_valid <= s2_deq;
      pix_x     <= s2_deq ? (x_cnt[10] ? 10'h3ff : x_cnt[9:0]) : '0;
      pix_y     <= s2_deq ? y_cnt : '0;
      sof       <= s2_deq && (x_cnt == '0) && (y_cnt == '0) && seen_vs;
      eol       <= line_end;

      // x saturates one past 1023 so a 1025th pixel can be flagged
      if (!s2_deq)        x_cnt <= '0;
      else if (!x_cnt[10]) x_cnt <= x_cnt + 11'd1;

      tick <= vs_rise;
      eval <= vs_rise & seen_vs;
      if (vs_rise) begin
        snap_good <= frame_good;
        snap_w    <= cur_w_nxt[9:0];
        snap_h    <= y_nxt;
        y_cnt     <= '0;
        cur_w     <= '0;
        ovf       <= 1'b0;
        mism      <= 1'b0;
        seen_vs   <= 1'b1;
        wd_cnt    <= '0;
      end else begin
        y_cnt <= y_nxt;
        cur_w <= cur_w_nxt;
        ovf   <= ovf_nxt;
        mism  <= mism_nxt;
        if (!wd_hit) wd_cnt <= wd_cnt + 20'd1;
      end
    end
  end

  assign same = (snap_w == cand_w) && (snap_h == cand_h);

  always_comb begin
    state_nxt = state;
    load_cand = 1'b0;
    load_act  = 1'b0;
    err       = 1'b0;
    if (wd_hit) begin
      state_nxt = UNLOCKED;
    end else if (eval) begin
      case (state)
        UNLOCKED: if (snap_good) begin
          state_nxt = CAND;
          load_cand = 1'b1;
        end
        CAND: if (!snap_good) begin
          state_nxt = UNLOCKED;
        end else if (same) begin
          state_nxt = LOCKED;
          load_act  = 1'b1;
        end else begin
          load_cand = 1'b1;
        end
        LOCKED: if (!snap_good) begin
          state_nxt = UNLOCKED;
          err       = 1'b1;
        end else if (!same) begin
          state_nxt = CAND;
          load_cand = 1'b1;
          err       = 1'b1;
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      state <= UNLOCKED;
      cand_w <= '0; cand_h <= '0;
      h_active <= '0; v_active <= '0;
      frame_locked <= 1'b0;
      geom_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state        <= state_nxt;
      frame_locked <= (state_nxt == LOCKED);
      geom_err     <= err;
      if (tick) frame_cnt <= frame_cnt + 8'd1;
      if (load_cand) begin
        cand_w <= snap_w;
        cand_h <= snap_h;
      end
      if (load_act) begin
        h_active <= snap_w;
        v_active <= snap_h;
      end
    end
  end

endmodule
